// File: rtl/id_pkg.sv
// Shared ID-stage definitions: RV32I opcodes, ALU operation codes (also consumed by EX),
// immediate formats and the decode-register FSM states.
package id_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [4:0] ALU_NOP   = 5'b00000;
    localparam logic [4:0] ALU_AND   = 5'b00100;
    localparam logic [4:0] ALU_OR    = 5'b00101;
    localparam logic [4:0] ALU_XOR   = 5'b00110;
    localparam logic [4:0] ALU_SLL   = 5'b01000;
    localparam logic [4:0] ALU_SRL   = 5'b01001;
    localparam logic [4:0] ALU_ADDI  = 5'b01100;
    localparam logic [4:0] ALU_ADD   = 5'b01101;
    localparam logic [4:0] ALU_SUB   = 5'b01110;
    localparam logic [4:0] ALU_BEQ   = 5'b10001;
    localparam logic [4:0] ALU_ADDR  = 5'b10100;
    localparam logic [4:0] ALU_STORE = 5'b10101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_TRAP,
        ST_HALT
    } state_e;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate generator: selects and sign-extends the I/S/B/J immediate.
// Zero latency; no handshake (pure function of instruction and format).
module id_imm_gen
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  logic [2:0]      imm_type_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (imm_type_i)
            IMM_I:   imm_o = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
            IMM_S:   imm_o = {{(XLEN-11){instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
            // B and J immediates encode halfword offsets, so bit 0 is always zero
            IMM_B:   imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_J:   imm_o = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// ID/EX register: decodes RV32I subset into EX controls; illegal op traps then halts until flush.
// Latency 1 cycle; in_ready is combinational, output held while out_valid && !out_ready.
// Optional ID_INSTR_CNT_EN adds instr_cnt, counting every out_valid && out_ready handshake.
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instr_i,
    input  logic [XLEN-1:0] PC_i,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      ALUop_o,
    output logic            ALUSrc1,
    output logic            ALUSrc2,
    output logic [XLEN-1:0] Imm,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic            RegWrite_o,
    output logic            MemRead_o,
    output logic            MemWrite_o,
    output logic            Branch_o,
    output logic            Jump_o,
    output logic [XLEN-1:0] PC_o,
`ifdef ID_INSTR_CNT_EN
    output logic [31:0]     instr_cnt,
`endif
    output logic            illegal_o
);

    state_e          state_q, state_d;
    logic            capture;

    logic [4:0]      dec_alu_op;
    logic            dec_src1, dec_src2;
    imm_type_e       dec_imm_type;
    logic            dec_rw, dec_mr, dec_mw, dec_br, dec_jp, dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rd;

    logic [4:0]      alu_op_q, rs1_q, rs2_q, rd_q;
    logic            src1_q, src2_q, rw_q, mr_q, mw_q, br_q, jp_q, illegal_q;
    logic [XLEN-1:0] imm_q, pc_q;

    wire  [6:0]      opcode = Instr_i[6:0];
    wire  [2:0]      funct3 = Instr_i[14:12];
    wire  [6:0]      funct7 = Instr_i[31:25];

    always_comb begin
        dec_alu_op   = ALU_NOP;
        dec_src1     = 1'b0;
        dec_src2     = 1'b0;
        dec_imm_type = IMM_NONE;
        dec_rw       = 1'b0;
        dec_mr       = 1'b0;
        dec_mw       = 1'b0;
        dec_br       = 1'b0;
        dec_jp       = 1'b0;
        dec_illegal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                if (funct7 == 7'b0000000) begin
                    dec_illegal = 1'b0;
                    case (funct3)
                        3'b000:  dec_alu_op = ALU_ADD;
                        3'b001:  dec_alu_op = ALU_SLL;
                        3'b100:  dec_alu_op = ALU_XOR;
                        3'b101:  dec_alu_op = ALU_SRL;
                        3'b110:  dec_alu_op = ALU_OR;
                        3'b111:  dec_alu_op = ALU_AND;
                        default: dec_illegal = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_illegal = 1'b0;
                    dec_alu_op  = ALU_SUB;
                end
                dec_rw = !dec_illegal;
            end
            OP_IMM: if (funct3 == 3'b000) begin
                dec_illegal = 1'b0; dec_alu_op = ALU_ADDI; dec_src2 = 1'b1;
                dec_imm_type = IMM_I; dec_rw = 1'b1;
            end
            OP_LOAD: if (funct3 == 3'b010) begin
                dec_illegal = 1'b0; dec_alu_op = ALU_ADDR; dec_src2 = 1'b1;
                dec_imm_type = IMM_I; dec_rw = 1'b1; dec_mr = 1'b1;
            end
            OP_STORE: if (funct3 == 3'b010) begin
                dec_illegal = 1'b0; dec_alu_op = ALU_STORE; dec_src2 = 1'b1;
                dec_imm_type = IMM_S; dec_mw = 1'b1;
            end
            OP_BRANCH: if (funct3 == 3'b000) begin
                dec_illegal = 1'b0; dec_alu_op = ALU_BEQ; dec_src1 = 1'b1; dec_src2 = 1'b1;
                dec_imm_type = IMM_B; dec_br = 1'b1;
            end
            OP_JALR: if (funct3 == 3'b000) begin
                dec_illegal = 1'b0; dec_alu_op = ALU_ADDR; dec_src2 = 1'b1;
                dec_imm_type = IMM_I; dec_rw = 1'b1; dec_jp = 1'b1;
            end
            OP_JAL: begin
                dec_illegal = 1'b0; dec_alu_op = ALU_ADDR; dec_src1 = 1'b1; dec_src2 = 1'b1;
                dec_imm_type = IMM_J; dec_rw = 1'b1; dec_jp = 1'b1;
            end
            default: ;
        endcase
    end

    // rd is meaningless without a writeback, so it is zeroed to keep hazard logic simple
    assign dec_rd = dec_rw ? Instr_i[11:7] : 5'd0;

    id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i    (Instr_i[31:7]),
        .imm_type_i (dec_imm_type),
        .imm_o      (dec_imm)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_EMPTY;
        else      state_q <= state_d;
    end

    // in_ready is gated by rst so every output reads 0 while reset is held
    always_comb begin
        in_ready  = rst && !flush &&
                    (state_q == ST_EMPTY || (state_q == ST_FULL && out_ready));
        out_valid = (state_q == ST_FULL) || (state_q == ST_TRAP);
        capture   = in_valid && in_ready;
        state_d   = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (capture) state_d = dec_illegal ? ST_TRAP : ST_FULL;
                ST_FULL:  if (capture)        state_d = dec_illegal ? ST_TRAP : ST_FULL;
                          else if (out_ready) state_d = ST_EMPTY;
                ST_TRAP:  if (out_ready) state_d = ST_HALT;
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_op_q  <= '0;
            src1_q    <= 1'b0;
            src2_q    <= 1'b0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rw_q      <= 1'b0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            br_q      <= 1'b0;
            jp_q      <= 1'b0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            // control clears so a discarded op cannot act; datapath fields just hold
            alu_op_q  <= '0;
            src1_q    <= 1'b0;
            src2_q    <= 1'b0;
            rw_q      <= 1'b0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            br_q      <= 1'b0;
            jp_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else if (capture) begin
            alu_op_q  <= dec_alu_op;
            src1_q    <= dec_src1;
            src2_q    <= dec_src2;
            imm_q     <= dec_imm;
            rs1_q     <= Instr_i[19:15];
            rs2_q     <= Instr_i[24:20];
            rd_q      <= dec_rd;
            rw_q      <= dec_rw;
            mr_q      <= dec_mr;
            mw_q      <= dec_mw;
            br_q      <= dec_br;
            jp_q      <= dec_jp;
            pc_q      <= PC_i;
            illegal_q <= dec_illegal;
        end
    end

    assign ALUop_o    = alu_op_q;
    assign ALUSrc1    = src1_q;
    assign ALUSrc2    = src2_q;
    assign Imm        = imm_q;
    assign rs1_o      = rs1_q;
    assign rs2_o      = rs2_q;
    assign rd_o       = rd_q;
    assign RegWrite_o = rw_q;
    assign MemRead_o  = mr_q;
    assign MemWrite_o = mw_q;
    assign Branch_o   = br_q;
    assign Jump_o     = jp_q;
    assign PC_o       = pc_q;
    assign illegal_o  = illegal_q;

`ifdef ID_INSTR_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        cnt_q <= '0;
        else if (out_valid && out_ready) cnt_q <= cnt_q + 32'd1;
    end

    assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed decode/stall/trap/reset cases, then random traffic checked by a
// 1-deep buffer + halt-flag reference model feeding a scoreboard queue.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] Instr_i = '0, PC_i = '0;
    logic        in_ready, out_valid, ALUSrc1, ALUSrc2;
    logic [4:0]  ALUop_o, rs1_o, rs2_o, rd_o;
    logic [31:0] Imm, PC_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, illegal_o;
`ifdef ID_INSTR_CNT_EN
    logic [31:0] instr_cnt;
    logic [31:0] mdl_cnt = '0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Instr_i(Instr_i), .PC_i(PC_i), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUop_o(ALUop_o), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .Imm(Imm),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .Branch_o(Branch_o), .Jump_o(Jump_o), .PC_o(PC_o),
`ifdef ID_INSTR_CNT_EN
        .instr_cnt(instr_cnt),
`endif
        .illegal_o(illegal_o)
    );

    typedef struct packed {
        logic [4:0]  alu;
        logic        s1, s2;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, br, jp;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    typedef enum {M_ILL, M_ADD, M_SUB, M_SLL, M_XOR, M_SRL, M_OR, M_AND,
                  M_ADDI, M_LW, M_SW, M_BEQ, M_JALR, M_JAL} mn_e;

    exp_t exp_q[$];
    logic halted = 1'b0;

    function automatic mn_e mnemonic(input logic [31:0] w);
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        if (op == 7'b0110011 && f7 == 7'd0) begin
            if (f3 == 3'd0) return M_ADD;
            if (f3 == 3'd1) return M_SLL;
            if (f3 == 3'd4) return M_XOR;
            if (f3 == 3'd5) return M_SRL;
            if (f3 == 3'd6) return M_OR;
            if (f3 == 3'd7) return M_AND;
        end
        if (op == 7'b0110011 && f7 == 7'b0100000 && f3 == 3'd0) return M_SUB;
        if (op == 7'b0010011 && f3 == 3'd0) return M_ADDI;
        if (op == 7'b0000011 && f3 == 3'd2) return M_LW;
        if (op == 7'b0100011 && f3 == 3'd2) return M_SW;
        if (op == 7'b1100011 && f3 == 3'd0) return M_BEQ;
        if (op == 7'b1100111 && f3 == 3'd0) return M_JALR;
        if (op == 7'b1101111) return M_JAL;
        return M_ILL;
    endfunction

    // Immediates from their bit fields by plain signed arithmetic
    function automatic logic [31:0] imm_of(input byte form, input logic [31:0] w);
        logic signed [31:0] sw;
        int v;
        sw = w;
        v  = 0;
        case (form)
            "I": v = int'(sw >>> 20);
            "S": v = int'(sw >>> 25) * 32 + int'(w[11:7]);
            "B": v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            "J": v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                     + int'(w[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        e = '0; e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        case (mnemonic(w))
            M_ADD:  begin e.alu = 5'b01101; e.rw = 1; end
            M_SUB:  begin e.alu = 5'b01110; e.rw = 1; end
            M_SLL:  begin e.alu = 5'b01000; e.rw = 1; end
            M_XOR:  begin e.alu = 5'b00110; e.rw = 1; end
            M_SRL:  begin e.alu = 5'b01001; e.rw = 1; end
            M_OR:   begin e.alu = 5'b00101; e.rw = 1; end
            M_AND:  begin e.alu = 5'b00100; e.rw = 1; end
            M_ADDI: begin e.alu = 5'b01100; e.s2 = 1; e.imm = imm_of("I", w); e.rw = 1; end
            M_LW:   begin e.alu = 5'b10100; e.s2 = 1; e.imm = imm_of("I", w); e.rw = 1; e.mr = 1; end
            M_SW:   begin e.alu = 5'b10101; e.s2 = 1; e.imm = imm_of("S", w); e.mw = 1; end
            M_BEQ:  begin e.alu = 5'b10001; e.s1 = 1; e.s2 = 1; e.imm = imm_of("B", w); e.br = 1; end
            M_JALR: begin e.alu = 5'b10100; e.s2 = 1; e.imm = imm_of("I", w); e.rw = 1; e.jp = 1; end
            M_JAL:  begin e.alu = 5'b10100; e.s1 = 1; e.s2 = 1; e.imm = imm_of("J", w); e.rw = 1; e.jp = 1; end
            default: e.ill = 1;
        endcase
        e.rd = e.rw ? w[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w; logic [6:0] op, f7; logic [2:0] f3; logic set_f7;
        w = $urandom; f3 = 3'($urandom); f7 = 7'd0; set_f7 = 1'b1; op = 7'b0110011;
        case ($urandom_range(0, 15))
            0: f3 = 3'd0;
            1: begin f3 = 3'd0; f7 = 7'b0100000; end
            2: f3 = 3'd1;
            3: f3 = 3'd4;
            4: f3 = 3'd5;
            5: f3 = 3'd6;
            6: f3 = 3'd7;
            7:  begin op = 7'b0010011; f3 = 3'd0; set_f7 = 0; end
            8:  begin op = 7'b0000011; f3 = 3'd2; set_f7 = 0; end
            9:  begin op = 7'b0100011; f3 = 3'd2; set_f7 = 0; end
            10: begin op = 7'b1100011; f3 = 3'd0; set_f7 = 0; end
            11: begin op = 7'b1100111; f3 = 3'd0; set_f7 = 0; end
            12: begin op = 7'b1101111; f3 = w[14:12]; set_f7 = 0; end
            13: f7 = 7'($urandom);
            14: return w;
            default: begin op = 7'b0010011; set_f7 = 0; end
        endcase
        w[6:0] = op; w[14:12] = f3;
        if (set_f7) w[31:25] = f7;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = iv; Instr_i = ins; PC_i = pc; out_ready = ordy; flush = fl;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decides readiness/capture and pushes expected decodes
    initial begin : model_proc
        logic mdl_rdy, cap_now;
        exp_t cap_item;
        forever begin
            @(negedge clk);
            #1;
            mdl_rdy = rst && !flush && !halted;
            if (exp_q.size() != 0) mdl_rdy = mdl_rdy && out_ready && !exp_q[0].ill;
            chk("model_in_ready", 32'(in_ready), 32'(mdl_rdy));
            cap_now  = in_valid && mdl_rdy;
            cap_item = ref_decode(Instr_i, PC_i);
            #2;
            if (cap_now) exp_q.push_back(cap_item);
        end
    end

    // Monitor: compares the presented decode with the scoreboard head, pops on handshake
    initial begin : monitor_proc
        exp_t dut_v, head;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0 && out_valid) begin
                    dut_v = {ALUop_o, ALUSrc1, ALUSrc2, Imm, rs1_o, rs2_o, rd_o, RegWrite_o,
                             MemRead_o, MemWrite_o, Branch_o, Jump_o, PC_o, illegal_o};
                    n_checks++;
                    if (dut_v !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL decode: got %h expected %h at %0t", dut_v, exp_q[0], $time);
                    end
                end
`ifdef ID_INSTR_CNT_EN
                chk("instr_cnt", instr_cnt, mdl_cnt);
                if (exp_q.size() != 0 && out_ready) mdl_cnt = mdl_cnt + 1;
`endif
                if (flush) begin
                    exp_q.delete();
                    halted = 1'b0;
                end else if (exp_q.size() != 0 && out_ready) begin
                    head = exp_q.pop_front();
                    if (head.ill) halted = 1'b1;
                end
            end
        end
    end

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADD2 = 32'h00310233;
    localparam logic [31:0] I_ADDI = 32'hFFF00293;
    localparam logic [31:0] I_BEQ  = 32'hFE208EE3;

    initial begin
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_ALUop", 32'(ALUop_o), 0);
        chk("rst_PC_o", PC_o, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        drive(1, I_ADD, 32'h100, 1, 0); settle();
        chk("add_valid", 32'(out_valid), 1);
        chk("add_ALUop", 32'(ALUop_o), 32'h0D);
        chk("add_src", 32'({ALUSrc1, ALUSrc2}), 0);
        chk("add_rs1", 32'(rs1_o), 1);
        chk("add_rs2", 32'(rs2_o), 2);
        chk("add_rd", 32'(rd_o), 3);
        chk("add_RegWrite", 32'(RegWrite_o), 1);
        chk("add_PC", PC_o, 32'h100);

        drive(1, I_ADDI, 32'h104, 1, 0); settle();
        chk("addi_ALUop", 32'(ALUop_o), 32'h0C);
        chk("addi_src2", 32'(ALUSrc2), 1);
        chk("addi_Imm", Imm, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(rd_o), 5);

        drive(1, I_BEQ, 32'h108, 1, 0); settle();
        chk("beq_ALUop", 32'(ALUop_o), 32'h11);
        chk("beq_src", 32'({ALUSrc1, ALUSrc2}), 3);
        chk("beq_Imm", Imm, 32'hFFFF_FFFC);
        chk("beq_Branch", 32'(Branch_o), 1);
        chk("beq_rd", 32'(rd_o), 0);

        for (int k = 0; k < 3; k++) begin
            drive(1, I_ADD2, 32'h10C, 0, 0);
            #1 chk("stall_in_ready", 32'(in_ready), 0);
            settle();
            chk("stall_ALUop", 32'(ALUop_o), 32'h11);
            chk("stall_Imm", Imm, 32'hFFFF_FFFC);
            chk("stall_PC", PC_o, 32'h108);
        end
        drive(1, I_ADD2, 32'h10C, 1, 0);
        #1 chk("release_in_ready", 32'(in_ready), 1);
        settle();
        chk("release_ALUop", 32'(ALUop_o), 32'h0D);
        chk("release_rd", 32'(rd_o), 4);

        drive(1, 32'h0, 32'h110, 1, 0); settle();
        chk("ill_illegal", 32'(illegal_o), 1);
        chk("ill_ALUop", 32'(ALUop_o), 0);
        chk("ill_valid", 32'(out_valid), 1);
        drive(1, I_ADD, 32'h114, 1, 0);
        #1 chk("trap_in_ready", 32'(in_ready), 0);
        settle();
        chk("halt_valid", 32'(out_valid), 0);
        drive(1, I_ADD, 32'h114, 1, 0);
        #1 chk("halt_in_ready", 32'(in_ready), 0);
        settle();
        drive(1, I_ADD, 32'h118, 1, 1);
        #1 chk("flush_in_ready", 32'(in_ready), 0);
        settle();
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_illegal", 32'(illegal_o), 0);
        drive(1, I_ADD, 32'h11C, 1, 0);
        #1 chk("resume_in_ready", 32'(in_ready), 1);
        settle();
        chk("resume_valid", 32'(out_valid), 1);
        chk("resume_PC", PC_o, 32'h11C);

        drive(0, 32'h0, 32'h0, 0, 0); settle();
        chk("prerst_valid", 32'(out_valid), 1);
        #1 rst = 1'b0;
        exp_q.delete(); halted = 1'b0;
`ifdef ID_INSTR_CNT_EN
        mdl_cnt = '0;
`endif
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_ALUop", 32'(ALUop_o), 0);
        chk("arst_rs1", 32'(rs1_o), 0);
        chk("arst_rd", 32'(rd_o), 0);
        chk("arst_RegWrite", 32'(RegWrite_o), 0);
        chk("arst_PC", PC_o, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        drive(1, I_ADDI, 32'h200, 1, 0); settle();
        chk("postrst_valid", 32'(out_valid), 1);
        chk("postrst_ALUop", 32'(ALUop_o), 32'h0C);
        chk("postrst_Imm", Imm, 32'hFFFF_FFFF);
        chk("postrst_PC", PC_o, 32'h200);

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end
        drive(0, 32'h0, 32'h0, 1, 1);
        drive(0, 32'h0, 32'h0, 1, 0);
        drive(0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Registered instruction decode stage (ID/EX pipeline register) that produces every control and operand-select input consumed by the execute stage: ALUop, ALUSrc1/ALUSrc2, sign-extended Imm, register indices, PC.
- Decodes the RV32I subset executed by the core.
- Holds one decoded instruction with valid/ready handshakes on both sides.
- Includes flush support and an illegal-instruction halt FSM.

Parameters:
XLEN, 32, datapath width of PC, Imm and instruction.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents Instr_i/PC_i
- in_ready  out  1  stage accepts this cycle (combinational)
- Instr_i  in  32  raw instruction
- PC_i  in  32  instruction address
- flush  in  1  discard held instruction, clear halt
- out_valid  out  1  decoded instruction valid toward EX
- out_ready  in  1  EX consumes this cycle
- ALUop_o  out  5  ALU operation code
- ALUSrc1  out  1  1: operand1 = PC, 0: register 1
- ALUSrc2  out  1  1: operand2 = Imm, 0: register 2
- Imm  out  32  sign-extended immediate
- rs1_o, rs2_o, rd_o  out  5 each  register indices
- RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o  out  1 each  control
- PC_o  out  32  PC of held instruction
- illegal_o  out  1  held instruction is undecodable

Behaviour:
- Reset: one clock (clk); reset (rst) is asynchronous and active-low.
  - While rst=0, all outputs are 0 and state is EMPTY.
- FSM states: EMPTY, FULL, TRAP, HALT.
  - EMPTY: out_valid=0.
  - FULL/TRAP: out_valid=1.
  - HALT: out_valid=0.
- in_ready = !flush && (EMPTY || (FULL && out_ready)).
- Capture occurs when in_valid && in_ready. All outputs register on the next clk edge (latency 1).
- Transitions:
  - EMPTY --capture legal--> FULL
  - EMPTY --capture illegal--> TRAP
  - FULL --out_ready, capture--> FULL or TRAP
  - FULL --out_ready, no capture--> EMPTY
  - TRAP --out_ready--> HALT
  - HALT --flush--> EMPTY
- flush wins over everything:
  - Next state is EMPTY.
  - Control bits, illegal_o and out_valid clear; datapath outputs hold.
  - No capture occurs that cycle.
- While out_valid=1 && out_ready=0, all outputs are held stable.
- Decode (opcode / funct3 / funct7 -> ALUop, ALUSrc1, ALUSrc2, Imm type, controls):
  - 0110011 R-type, ALUSrc=0,0, RegWrite:
    - add 000/0000000 -> 01101
    - sub 000/0100000 -> 01110
    - sll 001/0000000 -> 01000
    - xor 100/0000000 -> 00110
    - srl 101/0000000 -> 01001
    - or 110/0000000 -> 00101
    - and 111/0000000 -> 00100
  - 0010011 f3=000 addi -> 01100; 0,1; I-imm; RegWrite.
  - 0000011 f3=010 lw -> 10100; 0,1; I-imm; RegWrite, MemRead.
  - 0100011 f3=010 sw -> 10101; 0,1; S-imm; MemWrite.
  - 1100011 f3=000 beq -> 10001; 1,1; B-imm; Branch.
  - 1100111 f3=000 jalr -> 10100; 0,1; I-imm; RegWrite, Jump.
  - 1101111 jal -> 10100; 1,1; J-imm; RegWrite, Jump.
  - Anything else is illegal: ALUop 00000, all controls 0, Imm 0, illegal_o=1.
- Register indices:
  - rs1/rs2/rd always extracted from bits [19:15]/[24:20]/[11:7].
  - rd_o forced to 0 when RegWrite=0.
- Immediates: bit 31 sign-extends to 32 bits. B-imm and J-imm have bit0=0.

Optional Feature:
- Macro ID_INSTR_CNT_EN.
- Defined: adds output instr_cnt (32 bits).
  - Increments on each out_valid && out_ready; wraps 0xFFFFFFFF->0.
  - Reset to 0 by rst only; flush does not clear it.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package id_pkg: opcode constants, ALUop codes (shared with EX), Imm-type enum, FSM state enum.
- Sub-module id_imm_gen: combinational immediate generator, inputs Instr + Imm-type, output 32-bit Imm.

Test Plan:
- 0x002081B3 (add x3,x1,x2), PC_i=0x100, out_ready=1 -> next cycle:
  - out_valid=1, ALUop_o=01101, ALUSrc=0,0
  - rs1=1, rs2=2, rd=3, RegWrite=1, PC_o=0x100
- 0xFFF00293 (addi x5,x0,-1) -> ALUop_o=01100, ALUSrc2=1, Imm=0xFFFFFFFF, rd=5.
- 0xFE208EE3 (beq x1,x2,-4) -> ALUop_o=10001, ALUSrc1=1, ALUSrc2=1, Imm=0xFFFFFFFC, Branch=1, rd_o=0.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; release -> next instruction captured.
- 0x00000000 -> illegal_o=1, ALUop_o=0; after consume, in_ready=0 (HALT); flush=1 with in_valid=1 -> nothing captured, state EMPTY; next cycle capture resumes.
- rst low mid-FULL -> all outputs 0 immediately, without a clk edge; after release, first instruction decodes normally.
